riscv_mem_responder: RTL



---
 rtl/riscv_mem_responder_pkg.sv | 14 +
 rtl/riscv_mem_responder_if.sv | 23 ++
 rtl/riscv_mem_responder_clear_ctrl.sv | 55 +++++
 rtl/riscv_mem_responder.sv | 81 ++++++++
 4 files changed

// File: rtl/riscv_mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
package riscv_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Core-side instruction-fetch and byte-lane data bus.
interface riscv_mem_responder_if;
    import riscv_mem_pkg::*;

    logic [31:0]  inst_addr;
    logic [31:0]  inst;
    logic [31:0]  mem_addr;
    byte_t [0:3]  mem_data_in;
    byte_t [0:3]  mem_data_out;
    logic         mem_write_en;
    logic         halted;

    modport master (
        output inst_addr, mem_addr, mem_data_in, mem_write_en, halted,
        input  inst, mem_data_out
    );

    modport slave (
        input  inst_addr, mem_addr, mem_data_in, mem_write_en, halted,
        output inst, mem_data_out
    );

endinterface

// File: rtl/riscv_mem_responder_clear_ctrl.sv
// Post-reset clear sequencer: walks the storage one word per cycle, then parks in RUN.
//
// state | meaning
// CLEAR | zeroing bytes clr_ptr..clr_ptr+3 each cycle, busy=1
// RUN   | normal operation, terminal until next reset
module riscv_mem_clear_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - WORD_BYTES);
    localparam mem_state_t RST_STATE = RESET_CLEAR ? CLEAR : RUN;

    mem_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_next;

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= RST_STATE;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        clr_we       = 1'b0;
        busy         = 1'b0;
        case (state)
            CLEAR: begin
                clr_we       = 1'b1;
                busy         = 1'b1;
                clr_ptr_next = clr_ptr + ADDR_WIDTH'(WORD_BYTES);
                if (clr_ptr == LAST_PTR) state_next = RUN;
            end
            default: ;
        endcase
    end

    assign clr_addr = clr_ptr;

endmodule

// File: rtl/riscv_mem_responder.sv
// Byte-addressed memory serving the core's fetch and data ports, with bench preload.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    riscv_mem_responder_if.slave  bus,
    input  logic                  load_en,
    input  logic [31:0]           load_addr,
    input  logic [31:0]           load_data,
    output logic                  busy,
    output logic [31:0]           wr_count
);

    localparam int S = 2 ** ADDR_WIDTH;

    byte_t                 mem [0:S-1];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] inst_a, data_a, load_a;
    logic                  core_we;

    // Upper address bits alias onto storage and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.inst_addr[31:ADDR_WIDTH], bus.mem_addr[31:ADDR_WIDTH],
                              load_addr[31:ADDR_WIDTH]};

    assign inst_a = bus.inst_addr[ADDR_WIDTH-1:0];
    assign data_a = bus.mem_addr[ADDR_WIDTH-1:0];
    assign load_a = load_addr[ADDR_WIDTH-1:0];

    // Core writes lose to a same-cycle preload and are blocked while halted or clearing.
    assign core_we = !busy && !load_en && bus.mem_write_en && !bus.halted;

    riscv_mem_clear_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RESET_CLEAR (RESET_CLEAR)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_b    (rst_b),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Storage write port: clear sweep, then preload, then core lanes; offsets wrap.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (clr_we)
                mem[clr_addr + ADDR_WIDTH'(i)] <= '0;
            else if (load_en)
                mem[load_a + ADDR_WIDTH'(i)] <= load_data[BYTE_W*i +: BYTE_W];
            else if (core_we)
                mem[data_a + ADDR_WIDTH'(i)] <= bus.mem_data_in[i];
        end
    end

    // Combinational read ports, forced to zero while the clear is running.
    always_comb begin
        bus.inst         = '0;
        bus.mem_data_out = '0;
        if (!busy) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                bus.inst[BYTE_W*i +: BYTE_W] = mem[inst_a + ADDR_WIDTH'(i)];
                bus.mem_data_out[i]          = mem[data_a + ADDR_WIDTH'(i)];
            end
        end
    end

    // Accepted core write counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            wr_count <= '0;
        else if (core_we)
            wr_count <= wr_count + 32'd1;
    end

endmodule
